// File: rtl/alu_unit.sv
// Registered 32-bit integer ALU for the MIPS datapath.
// One-cycle latency: result, Zero and Overflow load on every rising edge.
module alu_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] ALUA,
    input  logic [WIDTH-1:0] ALUB,
    input  logic [2:0]       ALUOp,
    output logic [WIDTH-1:0] ALU,
    output logic             Zero,
    output logic             Overflow
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_OR  = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOR = 3'b101;
    localparam logic [2:0] OP_SLT = 3'b110;
    localparam logic [2:0] OP_LUI = 3'b111;

    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic             w_add_ovf;
    logic             w_sub_ovf;
    logic             w_lt;
    logic [WIDTH-1:0] w_res;
    logic             w_ovf;

    logic [WIDTH-1:0] r_alu;
    logic             r_zero;
    logic             r_ovf;

    assign w_sum  = ALUA + ALUB;
    assign w_diff = ALUA - ALUB;

    // Signed overflow from operand and result sign bits.
    assign w_add_ovf = (ALUA[WIDTH-1] == ALUB[WIDTH-1])
                    && (w_sum[WIDTH-1] != ALUA[WIDTH-1]);
    assign w_sub_ovf = (ALUA[WIDTH-1] != ALUB[WIDTH-1])
                    && (w_diff[WIDTH-1] != ALUA[WIDTH-1]);

    assign w_lt = $signed(ALUA) < $signed(ALUB);

    always_comb begin
        w_res = '0;
        w_ovf = 1'b0;
        case (ALUOp)
            OP_ADD: begin
                w_res = w_sum;
                w_ovf = w_add_ovf;
            end
            OP_SUB: begin
                w_res = w_diff;
                w_ovf = w_sub_ovf;
            end
            OP_OR:  w_res = ALUA | ALUB;
            OP_AND: w_res = ALUA & ALUB;
            OP_XOR: w_res = ALUA ^ ALUB;
            OP_NOR: w_res = ~(ALUA | ALUB);
            OP_SLT: w_res = {{(WIDTH-1){1'b0}}, w_lt};
            OP_LUI: w_res = {ALUB[WIDTH-17:0], 16'h0000};
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_alu  <= '0;
            r_zero <= 1'b1;
            r_ovf  <= 1'b0;
        end else begin
            r_alu  <= w_res;
            r_zero <= (w_res == '0);
            r_ovf  <= w_ovf;
        end
    end

    assign ALU      = r_alu;
    assign Zero     = r_zero;
    assign Overflow = r_ovf;

endmodule

// File: tb/tb_alu_unit.sv
// Bench for alu_unit: directed corner vectors, latency/reset checks,
// and random vectors against an arithmetic reference model.
module tb_alu_unit;

    logic        clk;
    logic        reset;
    logic [31:0] ALUA;
    logic [31:0] ALUB;
    logic [2:0]  ALUOp;
    logic [31:0] ALU;
    logic        Zero;
    logic        Overflow;

    int n_vec;
    int n_err;

    alu_unit #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .ALUA     (ALUA),
        .ALUB     (ALUB),
        .ALUOp    (ALUOp),
        .ALU      (ALU),
        .Zero     (Zero),
        .Overflow (Overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: operations computed as plain signed/unsigned integers.
    function automatic logic [32:0] ref_alu(input logic [2:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa;
        longint sb;
        longint ua;
        longint ub;
        longint r;
        logic   ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = longint'(a);
        ub  = longint'(b);
        r   = 0;
        ovf = 1'b0;
        case (op)
            3'd0: begin
                r   = sa + sb;
                ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
            end
            3'd1: begin
                r   = sa - sb;
                ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
            end
            3'd2: r = ua | ub;
            3'd3: r = ua & ub;
            3'd4: r = ua ^ ub;
            3'd5: r = 64'hFFFF_FFFF - (ua | ub);
            3'd6: r = (sa < sb) ? 1 : 0;
            3'd7: r = (ub % 65536) * 65536;
        endcase
        return {ovf, r[31:0]};
    endfunction

    task automatic drive(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        @(negedge clk);
        ALUOp = op;
        ALUA  = a;
        ALUB  = b;
        @(posedge clk);
        #1;
    endtask

    task automatic directed(input string tag, input logic [2:0] op,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] er, input logic eo);
        drive(op, a, b);
        chk({tag, ".res"}, ALU, er);
        chk({tag, ".zero"}, {31'd0, Zero}, {31'd0, er == 32'd0});
        chk({tag, ".ovf"}, {31'd0, Overflow}, {31'd0, eo});
    endtask

    task automatic random_vec(input int idx);
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [32:0] m;
        logic [31:0] pick [6];
        pick[0] = 32'h0000_0000;
        pick[1] = 32'h0000_0001;
        pick[2] = 32'h7FFF_FFFF;
        pick[3] = 32'h8000_0000;
        pick[4] = 32'hFFFF_FFFF;
        pick[5] = $urandom;
        op = 3'($urandom_range(0, 7));
        a  = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 5)]
                                         : $urandom;
        b  = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 5)]
                                         : $urandom;
        if ($urandom_range(0, 9) == 0) b = a;
        m = ref_alu(op, a, b);
        drive(op, a, b);
        chk($sformatf("rnd%0d.op%0d.res", idx, op), ALU, m[31:0]);
        chk($sformatf("rnd%0d.zero", idx), {31'd0, Zero},
            {31'd0, m[31:0] == 32'd0});
        chk($sformatf("rnd%0d.ovf", idx), {31'd0, Overflow},
            {31'd0, m[32]});
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        ALUOp = 3'd1;
        ALUA  = 32'h1234_5678;
        ALUB  = 32'h0000_0001;
        @(posedge clk);
        #1;
        chk("rst.res", ALU, 32'h0);
        chk("rst.zero", {31'd0, Zero}, 32'd1);
        chk("rst.ovf", {31'd0, Overflow}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        directed("add", 3'd0, 32'hFFFFFF0F, 32'h40000000, 32'h3FFFFF0F, 0);
        directed("sub", 3'd1, 32'hFFFFFF0F, 32'h40000000, 32'hBFFFFF0F, 0);
        directed("or",  3'd2, 32'hFFFFFF0F, 32'h40000000, 32'hFFFFFF0F, 0);
        directed("and", 3'd3, 32'hFFFFFF0F, 32'h40000000, 32'h40000000, 0);
        directed("xor", 3'd4, 32'hFFFFFF0F, 32'h40000000, 32'hBFFFFF0F, 0);
        directed("nor", 3'd5, 32'hFFFFFF0F, 32'h40000000, 32'h000000F0, 0);
        directed("slt", 3'd6, 32'hFFFFFF0F, 32'h40000000, 32'h00000001, 0);
        directed("lui", 3'd7, 32'hFFFFFF0F, 32'h40000000, 32'h00000000, 0);
        directed("addovf", 3'd0, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1);
        directed("subovf", 3'd1, 32'h80000000, 32'h1, 32'h7FFFFFFF, 1);
        directed("addwrap", 3'd0, 32'hFFFFFFFF, 32'h1, 32'h0, 0);
        directed("sltneg", 3'd6, 32'h80000000, 32'h7FFFFFFF, 32'h1, 0);
        directed("sltswap", 3'd6, 32'h7FFFFFFF, 32'h80000000, 32'h0, 0);
        directed("slteq", 3'd6, 32'h12345678, 32'h12345678, 32'h0, 0);
        directed("lui1", 3'd7, 32'hDEADBEEF, 32'h00001234, 32'h12340000, 0);
        directed("lui2", 3'd7, 32'h00000000, 32'hABCD5678, 32'h56780000, 0);

        // Latency: mid-cycle input change must not show until the next edge.
        directed("lat0", 3'd0, 32'h00000005, 32'h00000003, 32'h00000008, 0);
        @(negedge clk);
        ALUOp = 3'd1;
        #1;
        chk("lat.hold", ALU, 32'h00000008);
        @(posedge clk);
        #1;
        chk("lat.new", ALU, 32'h00000002);

        // Reset mid-stream after an ADD has loaded.
        directed("prerst", 3'd0, 32'h00000010, 32'h00000020, 32'h30, 0);
        @(negedge clk);
        reset = 1'b1;
        ALUOp = 3'd0;
        ALUA  = 32'h7FFFFFFF;
        ALUB  = 32'h00000001;
        @(posedge clk);
        #1;
        chk("rst2.res", ALU, 32'h0);
        chk("rst2.zero", {31'd0, Zero}, 32'd1);
        chk("rst2.ovf", {31'd0, Overflow}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 300; i++) random_vec(i);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
